// File: rtl/stage_decode_iq.sv
// Decode stage: in-order instruction queue feeding a registered ID-EX slot, with hazard stall and redirect.
// Optional feature macro RV_ID_BYPASS_EN: an instruction may issue straight from IF when the queue is empty.

package stage_decode_iq_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc_plus_four;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [2:0]  func3;
        logic        reg_wr_en;
        logic [4:0]  reg_wr_addr;
        logic        dmem_rd_en;
        logic        dmem_wr_en;
        logic [31:0] dmem_wr_data;
    } id_ex_reg_t;
endpackage

module instr_decoder
    import stage_decode_iq_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output id_ex_reg_t  dec,
    output logic        taken,
    output logic [31:0] target
);
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        wr;

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        dec              = '0;
        dec.valid        = 1'b1;
        dec.pc           = pc;
        dec.pc_plus_four = pc + 32'd4;
        dec.op_a         = rs1_data;
        dec.op_b         = rs2_data;
        dec.func3        = instr[14:12];
        dec.reg_wr_addr  = instr[11:7];
        dec.dmem_wr_data = rs2_data;
        wr               = 1'b0;
        taken            = 1'b0;
        target           = pc + imm_b;
        case (instr[6:0])
            7'h37: begin dec.op_a = '0; dec.op_b = imm_u; wr = 1'b1; end
            7'h17: begin dec.op_a = pc; dec.op_b = imm_u; wr = 1'b1; end
            // jumps hand the link value to EX as pc + 4
            7'h6f: begin
                dec.op_a = pc; dec.op_b = 32'd4; wr = 1'b1;
                taken = 1'b1; target = pc + imm_j;
            end
            7'h67: begin
                dec.op_a = pc; dec.op_b = 32'd4; wr = 1'b1;
                taken = 1'b1; target = (rs1_data + imm_i) & ~32'd1;
            end
            7'h63: begin
                case (instr[14:12])
                    3'b000:  taken = rs1_data == rs2_data;
                    3'b001:  taken = rs1_data != rs2_data;
                    3'b100:  taken = $signed(rs1_data) <  $signed(rs2_data);
                    3'b101:  taken = $signed(rs1_data) >= $signed(rs2_data);
                    3'b110:  taken = rs1_data <  rs2_data;
                    3'b111:  taken = rs1_data >= rs2_data;
                    default: taken = 1'b0;
                endcase
            end
            7'h03: begin dec.op_b = imm_i; wr = 1'b1; dec.dmem_rd_en = 1'b1; end
            7'h23: begin dec.op_b = imm_s; dec.dmem_wr_en = 1'b1; end
            7'h13: begin dec.op_b = imm_i; wr = 1'b1; end
            7'h33: wr = 1'b1;
            default: ;
        endcase
        dec.reg_wr_en = wr && (instr[11:7] != 5'd0);
    end
endmodule

module stage_decode_iq
    import stage_decode_iq_pkg::*;
#(
    parameter int IQ_DEPTH = 4,
    parameter int CNT_W    = $clog2(IQ_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             squash_i,
    input  logic             fetch_valid_i,
    output logic             fetch_ready_o,
    input  logic [31:0]      instr_i,
    input  logic [31:0]      pc_i,
    output logic [4:0]       rs1_addr_o,
    output logic [4:0]       rs2_addr_o,
    input  logic [31:0]      data_rs1_i,
    input  logic [31:0]      data_rs2_i,
    input  logic             ex_load_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_ready_i,
    output id_ex_reg_t       id_ex_reg_o,
    output logic             redirect_o,
    output logic [31:0]      redirect_addr_o,
    output logic [CNT_W-1:0] iq_count_o
);
    localparam int PTR_W = $clog2(IQ_DEPTH);

    logic [31:0]      q_instr [IQ_DEPTH];
    logic [31:0]      q_pc    [IQ_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    logic             push, pop, wr, bypass, q_empty, head_valid, hazard, issue, taken;
    logic [31:0]      head_instr, head_pc;
    id_ex_reg_t       dec;

    assign q_empty       = count == '0;
    assign fetch_ready_o = (count < CNT_W'(IQ_DEPTH)) && !rst_i;
    assign push          = fetch_valid_i && fetch_ready_o;
`ifdef RV_ID_BYPASS_EN
    assign bypass = q_empty && push;
`else
    assign bypass = 1'b0;
`endif
    // with an empty queue the head view falls through to IF (only meaningful when bypassing)
    assign head_valid = !q_empty || bypass;
    assign head_instr = q_empty ? instr_i : q_instr[rd_ptr];
    assign head_pc    = q_empty ? pc_i    : q_pc[rd_ptr];
    assign rs1_addr_o = head_instr[19:15];
    assign rs2_addr_o = head_instr[24:20];

    assign hazard = ex_load_i && (ex_rd_i != 5'd0) &&
                    ((ex_rd_i == rs1_addr_o) || (ex_rd_i == rs2_addr_o));
    assign issue  = head_valid && !hazard && !squash_i && !rst_i &&
                    (!id_ex_reg_o.valid || ex_ready_i);
    assign pop    = issue && !q_empty;
    assign wr     = push && !(bypass && issue);

    instr_decoder u_dec (
        .instr    (head_instr),
        .pc       (head_pc),
        .rs1_data (data_rs1_i),
        .rs2_data (data_rs2_i),
        .dec      (dec),
        .taken    (taken),
        .target   (redirect_addr_o)
    );

    assign redirect_o = issue && taken;
    assign iq_count_o = count;

    always_ff @(posedge clk) begin
        if (wr) begin
            q_instr[wr_ptr] <= instr_i;
            q_pc[wr_ptr]    <= pc_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i || squash_i) begin
            rd_ptr            <= '0;
            wr_ptr            <= '0;
            count             <= '0;
            id_ex_reg_o.valid <= 1'b0;
        end else begin
            // a redirect discards everything younger than the issuing head, including this cycle's push
            if (redirect_o) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (wr)  wr_ptr <= wr_ptr + 1'b1;
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                count <= count + CNT_W'(wr) - CNT_W'(pop);
            end
            if (issue)
                id_ex_reg_o <= dec;
            else if (id_ex_reg_o.valid && ex_ready_i)
                id_ex_reg_o.valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_stage_decode_iq.sv
// Randomized bench for stage_decode_iq against a queue-based reference model, plus directed scenarios.
// Also covers the RV_ID_BYPASS_EN build when that macro is defined.

module tb_stage_decode_iq;
    import stage_decode_iq_pkg::*;

`ifdef RV_ID_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i, squash_i, fetch_valid_i, fetch_ready_o;
    logic [31:0] instr_i, pc_i, data_rs1_i, data_rs2_i, redirect_addr_o;
    logic [4:0]  rs1_addr_o, rs2_addr_o, ex_rd_i;
    logic        ex_load_i, ex_ready_i, redirect_o;
    id_ex_reg_t  id_ex_reg_o;
    logic [2:0]  iq_count_o;

    always #5 clk = ~clk;

    stage_decode_iq dut (
        .clk(clk), .rst_i(rst_i), .squash_i(squash_i),
        .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o),
        .instr_i(instr_i), .pc_i(pc_i),
        .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
        .data_rs1_i(data_rs1_i), .data_rs2_i(data_rs2_i),
        .ex_load_i(ex_load_i), .ex_rd_i(ex_rd_i), .ex_ready_i(ex_ready_i),
        .id_ex_reg_o(id_ex_reg_o), .redirect_o(redirect_o),
        .redirect_addr_o(redirect_addr_o), .iq_count_o(iq_count_o)
    );

    // register file answers whatever the DUT asks for in the same cycle
    logic [31:0] rf [32];
    assign data_rs1_i = rf[rs1_addr_o];
    assign data_rs2_i = rf[rs2_addr_o];

    typedef enum int {K_ADDI, K_ADD, K_LW, K_SW, K_LUI, K_AUIPC, K_JAL, K_JALR, K_BR} kind_e;
    typedef struct {
        logic [31:0] instr, pc, imm;
        kind_e       kind;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
    } ent_t;
    typedef struct {
        logic [31:0] pc, opa, opb, wdata, tgt;
        logic        wen, drd, dwr, taken;
        logic [4:0]  wa;
    } xp_t;

    int   nchk = 0, nbad = 0;
    ent_t mq[$];
    logic m_valid = 1'b0;
    xp_t  m_x;

    logic        d_fv, d_exl, d_exr, d_sq, d_rst;
    logic [4:0]  d_exrd;
    ent_t        d_e;
    logic        obs_redir;
    logic [31:0] obs_raddr;
    logic [31:0] cur_pc = 32'h8000;
    logic [31:0] pool [4];
    logic [2:0]  f3s  [6];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic ent_t mk(kind_e k, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                                logic [2:0] f3, logic [31:0] imm, logic [31:0] pc);
        ent_t e;
        e.kind = k; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.f3 = f3; e.imm = imm; e.pc = pc;
        case (k)
            K_ADDI:  e.instr = {imm[11:0], rs1, 3'b000, rd, 7'h13};
            K_ADD:   e.instr = {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
            K_LW:    e.instr = {imm[11:0], rs1, 3'b010, rd, 7'h03};
            K_SW:    e.instr = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
            K_LUI:   e.instr = {imm[31:12], rd, 7'h37};
            K_AUIPC: e.instr = {imm[31:12], rd, 7'h17};
            K_JAL:   e.instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
            K_JALR:  e.instr = {imm[11:0], rs1, 3'b000, rd, 7'h67};
            default: e.instr = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
        endcase
        return e;
    endfunction

    function automatic ent_t rnd(logic [31:0] pc);
        kind_e       k = kind_e'($urandom_range(0, 8));
        logic [31:0] r = $urandom;
        logic [31:0] imm;
        case (k)
            K_LUI, K_AUIPC: imm = {r[31:12], 12'b0};
            K_JAL:          imm = {{11{r[20]}}, r[20:1], 1'b0};
            K_BR:           imm = {{19{r[12]}}, r[12:1], 1'b0};
            K_ADD:          imm = '0;
            default:        imm = {{20{r[11]}}, r[11:0]};
        endcase
        return mk(k, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  f3s[$urandom_range(0, 5)], imm, pc);
    endfunction

    // expected ID-EX contents and control-flow outcome, from the instruction's meaning
    function automatic xp_t expect_of(ent_t e);
        xp_t x;
        logic [31:0] a = rf[e.rs1], b = rf[e.rs2];
        x.pc = e.pc; x.opa = a; x.opb = b; x.wdata = b; x.wa = e.rd;
        x.wen = 1'b0; x.drd = 1'b0; x.dwr = 1'b0; x.taken = 1'b0; x.tgt = '0;
        case (e.kind)
            K_ADDI:  begin x.opb = e.imm; x.wen = 1'b1; end
            K_ADD:   x.wen = 1'b1;
            K_LW:    begin x.opb = e.imm; x.wen = 1'b1; x.drd = 1'b1; end
            K_SW:    begin x.opb = e.imm; x.dwr = 1'b1; end
            K_LUI:   begin x.opa = 0; x.opb = e.imm; x.wen = 1'b1; end
            K_AUIPC: begin x.opa = e.pc; x.opb = e.imm; x.wen = 1'b1; end
            K_JAL:   begin x.opa = e.pc; x.opb = 4; x.wen = 1'b1; x.taken = 1'b1; x.tgt = e.pc + e.imm; end
            K_JALR:  begin x.opa = e.pc; x.opb = 4; x.wen = 1'b1; x.taken = 1'b1; x.tgt = (a + e.imm) & ~32'd1; end
            default: begin
                case (e.f3)
                    3'd0: x.taken = (a == b);
                    3'd1: x.taken = (a != b);
                    3'd4: x.taken = ($signed(a) < $signed(b));
                    3'd5: x.taken = ($signed(a) >= $signed(b));
                    3'd6: x.taken = (a < b);
                    default: x.taken = (a >= b);
                endcase
                x.tgt = e.pc + e.imm;
            end
        endcase
        if (e.rd == 5'd0) x.wen = 1'b0;
        return x;
    endfunction

    task automatic cyc();
        ent_t h;
        xp_t  hx;
        bit   hp, fromq, rdy, acc, haz, iss;
        @(negedge clk);
        fetch_valid_i = d_fv; instr_i = d_e.instr; pc_i = d_e.pc;
        ex_load_i = d_exl; ex_rd_i = d_exrd; ex_ready_i = d_exr;
        squash_i = d_sq; rst_i = d_rst;
        #1;
        rdy = !d_rst && (mq.size() < 4);
        acc = d_fv && rdy;
        hp = 1'b0; fromq = 1'b0; h = d_e;
        if (mq.size() > 0) begin hp = 1'b1; fromq = 1'b1; h = mq[0]; end
        else if (BYP && acc) hp = 1'b1;
        haz = d_exl && (d_exrd != 0) && (d_exrd == h.instr[19:15] || d_exrd == h.instr[24:20]);
        iss = hp && !haz && !d_sq && !d_rst && (!m_valid || d_exr);
        hx  = expect_of(h);
        chk("fetch_ready", 32'(fetch_ready_o), 32'(rdy));
        chk("redirect", 32'(redirect_o), 32'(iss && hx.taken));
        if (iss && hx.taken) chk("redirect_addr", redirect_addr_o, hx.tgt);
        if (hp) begin
            chk("rs1_addr", 32'(rs1_addr_o), 32'(h.instr[19:15]));
            chk("rs2_addr", 32'(rs2_addr_o), 32'(h.instr[24:20]));
        end
        obs_redir = redirect_o;
        obs_raddr = redirect_addr_o;
        @(posedge clk);
        if (d_rst || d_sq) begin
            mq.delete();
            m_valid = 1'b0;
        end else begin
            if (iss) begin
                m_x = hx; m_valid = 1'b1;
                if (fromq) mq.delete(0);
            end else if (m_valid && d_exr) m_valid = 1'b0;
            if (iss && hx.taken) mq.delete();
            else if (acc && !(iss && !fromq)) mq.push_back(d_e);
        end
        #1;
        chk("iq_count", 32'(iq_count_o), mq.size());
        chk("id_ex.valid", 32'(id_ex_reg_o.valid), 32'(m_valid));
        if (m_valid) begin
            chk("id_ex.pc", id_ex_reg_o.pc, m_x.pc);
            chk("id_ex.pc_plus_four", id_ex_reg_o.pc_plus_four, m_x.pc + 4);
            chk("id_ex.op_a", id_ex_reg_o.op_a, m_x.opa);
            chk("id_ex.op_b", id_ex_reg_o.op_b, m_x.opb);
            chk("id_ex.reg_wr_en", 32'(id_ex_reg_o.reg_wr_en), 32'(m_x.wen));
            chk("id_ex.dmem_rd_en", 32'(id_ex_reg_o.dmem_rd_en), 32'(m_x.drd));
            chk("id_ex.dmem_wr_en", 32'(id_ex_reg_o.dmem_wr_en), 32'(m_x.dwr));
            if (m_x.wen) chk("id_ex.reg_wr_addr", 32'(id_ex_reg_o.reg_wr_addr), 32'(m_x.wa));
            if (m_x.dwr) chk("id_ex.dmem_wr_data", id_ex_reg_o.dmem_wr_data, m_x.wdata);
        end
    endtask

    task automatic idle();
        d_fv = 1'b0; d_exl = 1'b0; d_exrd = '0; d_exr = 1'b1; d_sq = 1'b0; d_rst = 1'b0;
    endtask

    task automatic branch_setup(input logic [31:0] b);
        rf[1] = 32'h55; rf[2] = b;
        d_exl = 1'b1; d_exrd = 5'd1; d_fv = 1'b1;
        d_e = mk(K_BR, 0, 1, 2, 3'd0, 32'd16, 32'h100); cyc();
        d_e = mk(K_ADDI, 3, 0, 0, 3'd0, 32'd1, 32'h104); cyc();
        d_e = mk(K_ADDI, 4, 0, 0, 3'd0, 32'd2, 32'h108); cyc();
        d_fv = 1'b0; d_exl = 1'b0;
        cyc();
    endtask

    initial begin
        pool[0] = 32'h5; pool[1] = 32'hFFFF_FFFF; pool[2] = 32'h8000_0000; pool[3] = 32'h7;
        f3s[0] = 3'd0; f3s[1] = 3'd1; f3s[2] = 3'd4; f3s[3] = 3'd5; f3s[4] = 3'd6; f3s[5] = 3'd7;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        idle();
        d_e = mk(K_ADDI, 0, 0, 0, 3'd0, 32'd0, 32'h0);

        // reset
        d_rst = 1'b1; cyc(); cyc();
        chk("rst_count", 32'(iq_count_o), 0);
        chk("rst_ready", 32'(fetch_ready_o), 0);
        d_rst = 1'b0; cyc();

        // back-to-back ADDI x1..x4: one issue per push, queue never exceeds one entry
        for (int i = 1; i <= 4; i++) begin
            d_fv = 1'b1;
            d_e = mk(K_ADDI, 5'(i), 0, 0, 3'd0, 32'(i), 32'h1000 + 32'(4 * i));
            cyc();
            chk("peak_count", 32'(iq_count_o <= 1), 1);
        end
        idle(); cyc();
        chk("addi_last_pc", id_ex_reg_o.pc, 32'h1010);
        cyc(); cyc();

        // backpressure: five pushes with EX stalled fill the queue
        d_exr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d_fv = 1'b1;
            d_e = mk(K_ADDI, 5'(i + 1), 0, 0, 3'd0, 32'(i), 32'h2000 + 32'(4 * i));
            cyc();
        end
        chk("full_count", 32'(iq_count_o), 4);
        chk("full_ready", 32'(fetch_ready_o), 0);
        chk("full_head_held", id_ex_reg_o.pc, 32'h2000);
        idle();
        for (int i = 0; i < 6; i++) cyc();

        // load-use hazard on rs1
        rf[5] = 32'd10; rf[7] = 32'd3;
        d_exl = 1'b1; d_exrd = 5'd5; d_fv = 1'b1;
        d_e = mk(K_ADD, 6, 5, 7, 3'd0, 32'd0, 32'h200); cyc();
        d_fv = 1'b0; cyc();
        chk("hazard_bubble", 32'(id_ex_reg_o.valid), 0);
        d_exl = 1'b0; cyc();
        chk("hazard_release_pc", id_ex_reg_o.pc, 32'h200);
        idle(); cyc();

        // taken BEQ at 0x100 with two entries behind
        branch_setup(32'h55);
        chk("beq_redirect", 32'(obs_redir), 1);
        chk("beq_target", obs_raddr, 32'h110);
        chk("beq_flush_count", 32'(iq_count_o), 0);
        idle(); cyc(); cyc();
        branch_setup(32'h66);
        chk("bne_data_redirect", 32'(obs_redir), 0);
        chk("bne_data_count", 32'(iq_count_o), 2);
        idle(); for (int i = 0; i < 4; i++) cyc();

        // squash with three queued entries and a simultaneous push
        d_exl = 1'b1; d_exrd = 5'd5; d_fv = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d_e = mk(K_ADD, 6, 5, 7, 3'd0, 32'd0, 32'h300 + 32'(4 * i)); cyc();
        end
        chk("pre_squash_count", 32'(iq_count_o), 3);
        d_sq = 1'b1; d_e = mk(K_ADDI, 1, 0, 0, 3'd0, 32'd9, 32'h30c); cyc();
        chk("squash_count", 32'(iq_count_o), 0);
        chk("squash_valid", 32'(id_ex_reg_o.valid), 0);
        idle(); cyc(); cyc();
        chk("squash_push_lost", 32'(id_ex_reg_o.valid), 0);

`ifdef RV_ID_BYPASS_EN
        // bypass: JALR issues at its accept edge
        rf[1] = 32'h203; d_fv = 1'b1;
        d_e = mk(K_JALR, 0, 1, 0, 3'd0, 32'd0, 32'h400); cyc();
        chk("bypass_redirect", 32'(obs_redir), 1);
        chk("bypass_target", obs_raddr, 32'h202);
        chk("bypass_count", 32'(iq_count_o), 0);
        chk("bypass_valid", 32'(id_ex_reg_o.valid), 1);
        idle(); cyc();
`endif

        // randomized traffic
        for (int i = 1; i < 32; i++) rf[i] = pool[$urandom_range(0, 3)];
        for (int i = 0; i < 3000; i++) begin
            d_rst  = ($urandom_range(0, 99) == 0);
            d_sq   = ($urandom_range(0, 39) == 0);
            d_fv   = ($urandom_range(0, 9) < 7);
            d_exl  = ($urandom_range(0, 3) == 0);
            d_exrd = 5'($urandom_range(0, 7));
            d_exr  = ($urandom_range(0, 9) < 7);
            d_e    = rnd(cur_pc);
            cur_pc = cur_pc + 32'd4;
            cyc();
        end

        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end
endmodule
